// File: rtl/pixel_drain.sv
// Drains serialiser batches into a frame memory, one pixel byte per accepted cycle.
// Optional PIXEL_DRAIN_CHECKSUM_EN adds a per-frame modulo-2^16 byte checksum.
module pixel_drain #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17,
    parameter int BATCH        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              batch_valid,
    input  logic [7:0]        ser_data,
    input  logic              wr_ready,
    input  logic              frame_restart,
    output logic              shift,
    output logic              batch_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
`ifdef PIXEL_DRAIN_CHECKSUM_EN
    output logic [15:0]       frame_sum,
    output logic              sum_valid,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a byte moves to memory in a cycle where wr_en && wr_ready;
    // the serialiser advances in that same cycle only when shift is high.

    localparam int CNT_W = $clog2(BATCH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BATCH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        shift      = 1'b0;
        batch_ack  = 1'b0;
        wr_en      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_restart) begin
                    addr_d = '0;
                end
                if (batch_valid) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                wr_en = 1'b1;
                // A restart mid-batch waits so the batch stays contiguous.
                if (frame_restart) begin
                    pend_d = 1'b1;
                end
                if (wr_ready) begin
                    shift      = (cnt_q != CNT_LAST);
                    frame_done = (addr_q == ADDR_LAST);
                    addr_d     = frame_done ? '0 : addr_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ACK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ACK: begin
                batch_ack = 1'b1;
                state_d   = IDLE;
                pend_d    = 1'b0;
                if (pend_q || frame_restart) begin
                    addr_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
        end
    end

    assign wr_addr   = addr_q;
    assign wr_data   = ser_data;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

`ifdef PIXEL_DRAIN_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic        sum_valid_q, sum_valid_d;
    logic        accept;
    logic        restart_applied;

    assign accept          = (state_q == XFER) && wr_ready;
    assign restart_applied = ((state_q == IDLE) && frame_restart) ||
                             ((state_q == ACK) && (pend_q || frame_restart));

    always_comb begin
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        sum_valid_d = 1'b0;
        if (accept) begin
            if (frame_done) begin
                frame_sum_d = sum_q + {8'h00, ser_data};
                sum_valid_d = 1'b1;
                sum_d       = '0;
            end else begin
                sum_d = sum_q + {8'h00, ser_data};
            end
        end
        if (restart_applied) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            frame_sum_q <= frame_sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign frame_sum = frame_sum_q;
    assign sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_pixel_drain.sv
// Self-checking bench for pixel_drain: directed batch table plus randomized batches
// compared against a frame-address/byte reference model.
module tb_pixel_drain;

    localparam int FP = 40;
    localparam int AW = 17;
    localparam int B  = 16;
    localparam int EW = AW + 10;
    localparam int IW = $clog2(B);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          batch_valid = 1'b0;
    logic [7:0]    ser_data;
    logic          wr_ready = 1'b0;
    logic          frame_restart = 1'b0;
    logic          shift, batch_ack, wr_en, frame_done, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [1:0]    dbg_state;
`ifdef PIXEL_DRAIN_CHECKSUM_EN
    logic [15:0]   frame_sum;
    logic          sum_valid;
    logic [15:0]   sum_q[$];
    int            run_sum;
`endif

    pixel_drain #(.FRAME_PIXELS(FP), .ADDR_W(AW), .BATCH(B)) dut (
        .clk(clk), .rst(rst), .batch_valid(batch_valid), .ser_data(ser_data),
        .wr_ready(wr_ready), .frame_restart(frame_restart), .shift(shift),
        .batch_ack(batch_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .busy(busy),
`ifdef PIXEL_DRAIN_CHECKSUM_EN
        .frame_sum(frame_sum), .sum_valid(sum_valid),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Serialiser stand-in: holds one batch, advances on shift.
    logic [7:0]    batch_mem [0:B-1];
    logic [IW-1:0] ser_idx = '0;
    assign ser_data = batch_mem[ser_idx];
    always @(posedge clk) begin
        if (rst || batch_ack) ser_idx <= '0;
        else if (shift)       ser_idx <= ser_idx + 1'b1;
    end

    typedef struct {
        int pattern;      // 0 random, 1 0x10+i, 2 all 0xFF
        int stall_mode;   // 0 none, 1 random, 2 three cycles at byte 5
        bit restart_with;
        int restart_at;
        int abort_at;
        int exp_start;
        int exp_ack;      // -1: no ack expected
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    int            model_addr = 0;
    bit            restart_req = 0;
    bit            prev_fdone = 0;
    bit            cyc_acc, cyc_stall, seen_ack, ack_ok;
    int            acc_addr;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: observe at the falling edge, then return just after the next rising edge.
    task automatic tick();
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        @(negedge clk);
        cyc_acc = 0; cyc_stall = 0; seen_ack = batch_ack;
        ack_ok  = !wr_en && !shift && busy;
        if (!rst) begin
`ifdef PIXEL_DRAIN_CHECKSUM_EN
            if (sum_valid || prev_fdone) begin
                check(sum_valid == prev_fdone, "sum_valid_timing", sum_valid, prev_fdone);
                if (sum_valid && sum_q.size() > 0) begin
                    logic [15:0] es;
                    es = sum_q.pop_front();
                    check(frame_sum == es, "frame_sum", frame_sum, es);
                end
            end
`endif
            if (wr_en && wr_ready) begin
                cyc_acc  = 1;
                acc_addr = int'(wr_addr);
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_write", wr_addr, 0);
                end else begin
                    e   = exp_q.pop_front();
                    got = {wr_addr, wr_data, shift, frame_done};
                    check(got == e, "write_addr_data_shift_done", got, e);
`ifdef PIXEL_DRAIN_CHECKSUM_EN
                    run_sum = (run_sum + int'(e[9:2])) % 65536;
                    if (e[0]) begin
                        sum_q.push_back(16'(run_sum));
                        run_sum = 0;
                    end
`endif
                end
            end else begin
                check(!shift && !frame_done, "no_pulse_without_accept", {shift, frame_done}, 0);
                if (wr_en) begin
                    cyc_stall = 1;
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        check(wr_addr == e[EW-1 -: AW], "stall_addr_hold", wr_addr, e[EW-1 -: AW]);
                    end
                end
            end
            prev_fdone = wr_en && wr_ready && frame_done;
        end else begin
            prev_fdone = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_batch(input vec_t v, output int start_addr, output int ack_cyc);
        int  base, acc, stalls, stall_done;
        bit  fired, aborted;
        for (int i = 0; i < B; i++) begin
            if (v.pattern == 1)      batch_mem[i] = 8'h10 + 8'(i);
            else if (v.pattern == 2) batch_mem[i] = 8'hFF;
            else                     batch_mem[i] = 8'($urandom_range(0, 255));
        end
        // Reference: batch is BATCH consecutive pixels from the frame cursor, modulo FP.
        if (restart_req || v.restart_with) begin
            base = 0;
`ifdef PIXEL_DRAIN_CHECKSUM_EN
            run_sum = 0;
`endif
        end else begin
            base = model_addr;
        end
        restart_req = 0;
        for (int i = 0; i < B; i++) begin
            int a;
            a = (base + i) % FP;
            exp_q.push_back({AW'(a), batch_mem[i], (i < B - 1), (a == FP - 1)});
        end
        model_addr = (base + B) % FP;

        batch_valid   = 1'b1;
        frame_restart = v.restart_with;
        wr_ready      = (v.stall_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick();
        batch_valid   = 1'b0;   // dropped mid-batch on purpose; the batch must still finish
        frame_restart = 1'b0;
        acc = 0; stalls = 0; stall_done = 0; fired = 0; aborted = 0;
        start_addr = -1; ack_cyc = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (v.stall_mode == 1) begin
                wr_ready = ($urandom_range(0, 3) != 0);
            end else if (v.stall_mode == 2 && acc == 5 && stall_done < 3) begin
                wr_ready = 1'b0;
                stall_done++;
            end else begin
                wr_ready = 1'b1;
            end
            if (v.restart_at >= 0 && !fired && acc == v.restart_at) begin
                frame_restart = 1'b1;
                fired         = 1;
                restart_req   = 1;
            end
            if (v.abort_at >= 0 && acc == v.abort_at) begin
                rst      = 1'b1;
                wr_ready = 1'b0;
                tick();
                rst = 1'b0;
                exp_q.delete();
                model_addr  = 0;
                restart_req = 0;
`ifdef PIXEL_DRAIN_CHECKSUM_EN
                sum_q.delete();
                run_sum = 0;
                check(frame_sum == 16'h0, "abort_frame_sum", frame_sum, 0);
`endif
                check(!busy && wr_addr == '0 && !batch_ack && !wr_en, "abort_idle_addr0",
                      {busy, wr_en, batch_ack, wr_addr}, 0);
                aborted = 1;
                break;
            end
            tick();
            frame_restart = 1'b0;
            if (cyc_acc) begin
                if (acc == 0) start_addr = acc_addr;
                acc++;
            end
            if (cyc_stall) stalls++;
            if (seen_ack) begin
                ack_cyc = cyc;
                check(ack_ok, "ack_cycle_outputs", {wr_en, shift, busy}, 3'b001);
                break;
            end
        end
        wr_ready = 1'b1;
        if (!aborted) begin
            check(ack_cyc == B + 1 + stalls, "ack_latency", ack_cyc, B + 1 + stalls);
            check(exp_q.size() == 0, "all_bytes_written", exp_q.size(), 0);
        end else begin
            check(ack_cyc == -1, "abort_no_ack", ack_cyc, -1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int   sa, ac;

        for (int i = 0; i < B; i++) batch_mem[i] = 8'h00;
        //                pat stall rw  r_at abrt start ack
        vecs[0] = '{1, 0, 0, -1, -1,  0, 17};  // plain batch from reset
        vecs[1] = '{1, 2, 0, -1, -1, 16, 20};  // 3-cycle stall on byte 5
        vecs[2] = '{0, 0, 0, -1, -1, 32, 17};  // crosses frame end after byte 7
        vecs[3] = '{0, 0, 1, -1, -1,  0, 17};  // restart together with batch_valid
        vecs[4] = '{0, 0, 0,  4, -1, 16, 17};  // restart at byte 4 (wr_addr 20), stays pending
        vecs[5] = '{0, 0, 0, -1,  9,  0, -1};  // reset at byte 9
        vecs[6] = '{2, 0, 0, -1, -1,  0, 17};  // first batch after abort
        vecs[7] = '{2, 1, 0, B,  -1, 16, -2};  // restart during ACK, random stalls

        // Reset with batch_valid held high must stay idle.
        rst = 1'b1; batch_valid = 1'b1; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!busy && dbg_state == 2'd0, "reset_idle", {busy, dbg_state}, 0);
        check(wr_addr == '0, "reset_wr_addr", wr_addr, 0);
        check(!wr_en && !shift && !batch_ack && !frame_done, "reset_outputs",
              {wr_en, shift, batch_ack, frame_done}, 0);
`ifdef PIXEL_DRAIN_CHECKSUM_EN
        run_sum = 0;
        check(frame_sum == 16'h0 && !sum_valid, "reset_sum", {sum_valid, frame_sum}, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0; batch_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            send_batch(vecs[k], sa, ac);
            check(sa == vecs[k].exp_start, "table_start_addr", sa, vecs[k].exp_start);
            if (vecs[k].exp_ack != -2)
                check(ac == vecs[k].exp_ack, "table_ack_cycle", ac, vecs[k].exp_ack);
        end
        // vecs[7] left a restart pending in ACK: next batch must begin at 0.
        rv = '{0, 0, 0, -1, -1, 0, 17};
        send_batch(rv, sa, ac);
        check(sa == 0, "restart_in_ack_start", sa, 0);

        for (int k = 0; k < 60; k++) begin
            rv.pattern      = 0;
            rv.stall_mode   = $urandom_range(0, 1);
            rv.restart_with = ($urandom_range(0, 9) == 0);
            rv.restart_at   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, B) : -1;
            rv.abort_at     = -1;
            send_batch(rv, sa, ac);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
